// File: rtl/mdu_hilo_unit.sv
// -----------------------------------------------------------------------------
// mdu_hilo_unit
//   Multiply/divide unit with HI/LO registers for the E stage of the pipelined
//   MIPS core. MULT/MULTU/DIV/DIVU run for a fixed number of busy cycles.
//   MTHI/MTLO write in one cycle. HI/LO are read combinationally (MFHI/MFLO).
//
//   Optional feature macro: MDU_MADD_EN
//     defined   : MADD/MADDU/MSUB/MSUBU accumulate into {hi,lo}
//     undefined : ops 7..10 are NOPs and no accumulate adder is built
//
// Ports
//   clk     in   1      clock, rising edge
//   reset   in   1      asynchronous, active-high
//   start   in   1      op valid in E this cycle
//   op      in   4      1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//                       7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, others NOP
//   cancel  in   1      exception/flush in the launch cycle
//   a       in   WIDTH  rs operand
//   b       in   WIDTH  rt operand
//   busy    out  1      long op in flight
//   done    out  1      one-cycle pulse when the new HI/LO become visible
//   hi      out  WIDTH  HI register
//   lo      out  WIDTH  LO register
// -----------------------------------------------------------------------------
module mdu_hilo_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0]    CNT_MULT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    CNT_DIV  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_res;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_long;
  logic               w_mthi;
  logic               w_mtlo;
  logic               w_signed;
  logic               w_is_div;
  logic [CW-1:0]      w_cnt_load;
`ifdef MDU_MADD_EN
  logic               w_acc_add;
  logic               w_acc_sub;
`endif

  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;

  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_b_safe;
  logic [WIDTH-1:0]   w_q_mag;
  logic [WIDTH-1:0]   w_r_mag;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [2*WIDTH-1:0] w_div_res;
  logic [2*WIDTH-1:0] w_res;

  // Opcode decode: operation class, signedness and busy length
  always_comb begin
    w_long     = 1'b0;
    w_mthi     = 1'b0;
    w_mtlo     = 1'b0;
    w_signed   = 1'b0;
    w_is_div   = 1'b0;
    w_cnt_load = CNT_MULT;
`ifdef MDU_MADD_EN
    w_acc_add  = 1'b0;
    w_acc_sub  = 1'b0;
`endif
    case (op)
      OP_MULT: begin
        w_long   = 1'b1;
        w_signed = 1'b1;
      end
      OP_MULTU: begin
        w_long = 1'b1;
      end
      OP_DIV: begin
        w_long     = 1'b1;
        w_signed   = 1'b1;
        w_is_div   = 1'b1;
        w_cnt_load = CNT_DIV;
      end
      OP_DIVU: begin
        w_long     = 1'b1;
        w_is_div   = 1'b1;
        w_cnt_load = CNT_DIV;
      end
      OP_MTHI: begin
        w_mthi = 1'b1;
      end
      OP_MTLO: begin
        w_mtlo = 1'b1;
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        w_long    = 1'b1;
        w_signed  = 1'b1;
        w_acc_add = 1'b1;
      end
      OP_MADDU: begin
        w_long    = 1'b1;
        w_acc_add = 1'b1;
      end
      OP_MSUB: begin
        w_long    = 1'b1;
        w_signed  = 1'b1;
        w_acc_sub = 1'b1;
      end
      OP_MSUBU: begin
        w_long    = 1'b1;
        w_acc_sub = 1'b1;
      end
`endif
      default: begin
        w_long = 1'b0;
      end
    endcase
  end

  // busy blocks every launch, including MTHI/MTLO, so nothing queues
  assign w_accept = start & ~cancel & ~r_busy;

  // A 2W x 2W product truncated to 2W bits equals the exact signed/unsigned
  // W x W product once the operands are sign- or zero-extended.
  assign w_mul_a = w_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign w_mul_b = w_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign w_prod  = w_mul_a * w_mul_b;

  // Signed divide by magnitudes: the quotient is negated when the signs differ,
  // and the remainder follows the dividend. The overflow case (-2^(W-1) / -1)
  // falls out as quotient = a, remainder = 0 without special handling.
  assign w_a_neg   = w_signed & a[WIDTH-1];
  assign w_b_neg   = w_signed & b[WIDTH-1];
  assign w_a_mag   = w_a_neg ? (~a + ONE_W) : a;
  assign w_b_mag   = w_b_neg ? (~b + ONE_W) : b;
  assign w_b_zero  = (b == {WIDTH{1'b0}});
  assign w_b_safe  = w_b_zero ? ONE_W : w_b_mag;
  assign w_q_mag   = w_a_mag / w_b_safe;
  assign w_r_mag   = w_a_mag % w_b_safe;
  assign w_q       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + ONE_W) : w_q_mag;
  assign w_r       = w_a_neg ? (~w_r_mag + ONE_W) : w_r_mag;
  assign w_div_res = w_b_zero ? {a, {WIDTH{1'b1}}} : {w_r, w_q};

  // Select the 2W-bit result that is latched on the accept edge
  always_comb begin
    w_res = w_prod;
    if (w_is_div) begin
      w_res = w_div_res;
    end else begin
`ifdef MDU_MADD_EN
      if (w_acc_add) begin
        w_res = {r_hi, r_lo} + w_prod;
      end else if (w_acc_sub) begin
        w_res = {r_hi, r_lo} - w_prod;
      end else begin
        w_res = w_prod;
      end
`else
      w_res = w_prod;
`endif
    end
  end

  // IDLE/BUSY control, cycle counter and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= {CW{1'b0}};
      r_res   <= {(2*WIDTH){1'b0}};
      r_hi    <= {WIDTH{1'b0}};
      r_lo    <= {WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept & w_long) begin
            r_res   <= w_res;
            r_cnt   <= w_cnt_load;
            r_state <= ST_BUSY;
            r_busy  <= 1'b1;
          end else if (w_accept & w_mthi) begin
            r_hi <= a;
          end else if (w_accept & w_mtlo) begin
            r_lo <= a;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (r_cnt == CNT_ONE) begin
            r_hi    <= r_res[2*WIDTH-1:WIDTH];
            r_lo    <= r_res[WIDTH-1:0];
            r_cnt   <= {CW{1'b0}};
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_mdu_hilo_unit
//   Self-checking bench for mdu_hilo_unit (WIDTH=32, MULT_CYCLES=5,
//   DIV_CYCLES=10). A table of fixed vectors, hand-written multi-cycle
//   sequences, and randomized ops checked against an arithmetic reference.
//   Honours MDU_MADD_EN to pick the expected behaviour of ops 7..10.
// -----------------------------------------------------------------------------
module tb_mdu_hilo_unit;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_hilo_unit #(
    .WIDTH      (32),
    .MULT_CYCLES(NM),
    .DIV_CYCLES (ND)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .cancel(cancel),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_long(input logic [3:0] o);
    case (o)
      4'd1, 4'd2, 4'd3, 4'd4: return 1'b1;
`ifdef MDU_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic int cycles_of(input logic [3:0] o);
    return (o == 4'd3 || o == 4'd4) ? ND : NM;
  endfunction

  // Reference result of a long op, straight from the arithmetic definitions
  function automatic logic [63:0] ref_long(input logic [3:0] o, input logic [31:0] av,
                                           input logic [31:0] bv, input logic [63:0] acc);
    longint      sa, sb, q, r;
    logic [63:0] ps, pu;
    logic [31:0] uq, ur;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ps = 64'(sa * sb);
    pu = {32'd0, av} * {32'd0, bv};
    case (o)
      4'd1: return ps;
      4'd2: return pu;
      4'd3: begin
        if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
        uq = av / bv;
        ur = av % bv;
        return {ur, uq};
      end
      4'd7:  return acc + ps;
      4'd8:  return acc + pu;
      4'd9:  return acc - ps;
      4'd10: return acc - pu;
      default: return acc;
    endcase
  endfunction

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] av,
                                        input logic [31:0] bv, input logic c);
    if (c) return {m_hi, m_lo};
    if (is_long(o)) return ref_long(o, av, bv, {m_hi, m_lo});
    if (o == 4'd5) return {av, m_lo};
    if (o == 4'd6) return {m_hi, av};
    return {m_hi, m_lo};
  endfunction

  // Launch one op and follow it to completion, comparing against eh/el
  task automatic run_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic c, input logic [31:0] eh, input logic [31:0] el);
    bit lng;
    int n;
    int bad;
    lng = is_long(o) && !c;
    n   = cycles_of(o);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv; cancel = c;
    @(negedge clk);
    // scramble inputs after launch: they must not matter any more
    start = 1'b0; cancel = 1'b0;
    op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
    if (lng) begin
      check("busy_rise", {62'd0, busy, done}, 64'd2);
      bad = 0;
      for (int k = 2; k <= n; k++) begin
        @(negedge clk);
        if (!(busy === 1'b1 && done === 1'b0 && hi === m_hi && lo === m_lo)) bad++;
      end
      check("busy_hold", 64'(bad), 64'd0);
      @(negedge clk);
      check("done_pulse", {62'd0, busy, done}, 64'd1);
      check("result", {hi, lo}, {eh, el});
      @(negedge clk);
      check("done_fall", {62'd0, busy, done}, 64'd0);
    end else begin
      check("short_flags", {62'd0, busy, done}, 64'd0);
      check("short_hilo", {hi, lo}, {eh, el});
    end
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    logic [63:0] e;
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    logic        rc;
    int          bad;

    reset = 1'b1; start = 1'b0; op = 4'd0; cancel = 1'b0; a = 32'd0; b = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;

    tbl[0]  = '{4'd1,  32'hFFFF_FFFF, 32'h2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[1]  = '{4'd2,  32'hFFFF_FFFF, 32'h2,         1'b0, 32'h0000_0001, 32'hFFFF_FFFE};
    tbl[2]  = '{4'd3,  32'hFFFF_FFF9, 32'h2,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3]  = '{4'd3,  32'h0000_1234, 32'h0,         1'b0, 32'h0000_1234, 32'hFFFF_FFFF};
    tbl[4]  = '{4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000};
    tbl[5]  = '{4'd4,  32'hFFFF_FFFF, 32'h10,        1'b0, 32'h0000_000F, 32'h0FFF_FFFF};
    tbl[6]  = '{4'd1,  32'h0000_0003, 32'h3,         1'b1, 32'h0000_000F, 32'h0FFF_FFFF};
    tbl[7]  = '{4'd5,  32'h0000_00AA, 32'h0,         1'b0, 32'h0000_00AA, 32'h0FFF_FFFF};
    tbl[8]  = '{4'd6,  32'hFFFF_FFFF, 32'h0,         1'b0, 32'h0000_00AA, 32'hFFFF_FFFF};
    tbl[9]  = '{4'd5,  32'h0000_0000, 32'h0,         1'b0, 32'h0000_0000, 32'hFFFF_FFFF};
`ifdef MDU_MADD_EN
    tbl[10] = '{4'd8,  32'h0000_0001, 32'h1,         1'b0, 32'h0000_0001, 32'h0000_0000};
`else
    tbl[10] = '{4'd8,  32'h0000_0001, 32'h1,         1'b0, 32'h0000_0000, 32'hFFFF_FFFF};
`endif
    tbl[11] = '{4'd0,  32'h1234_5678, 32'h9,         1'b0, tbl[10].eh,    tbl[10].el};
    tbl[12] = '{4'd15, 32'h1234_5678, 32'h9,         1'b0, tbl[10].eh,    tbl[10].el};

    // reset state, held and after release
    repeat (2) @(negedge clk);
    check("reset_hold_hilo", {hi, lo}, 64'd0);
    check("reset_hold_flags", {62'd0, busy, done}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_rel_hilo", {hi, lo}, 64'd0);

    // fixed vectors
    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].eh, tbl[i].el);
    end

    // starts inside the busy window are dropped (MULTU and MTLO)
    run_op(4'd5, 32'h0000_00AA, 32'd0, 1'b0, 32'h0000_00AA, m_lo);
    @(negedge clk); start = 1'b1; op = 4'd1; a = 32'd2; b = 32'd3;          // t
    @(negedge clk); start = 1'b0;                                           // t+1
    @(negedge clk); start = 1'b1; op = 4'd2; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; // t+2
    @(negedge clk); op = 4'd6; a = 32'h55;                                  // t+3
    @(negedge clk); start = 1'b0;                                           // t+4
    check("window_busy", {62'd0, busy, done}, 64'd2);
    check("window_hilo_old", {hi, lo}, {32'h0000_00AA, m_lo});
    @(negedge clk);                                                         // t+5
    @(negedge clk);                                                         // t+6
    check("window_done", {62'd0, busy, done}, 64'd1);
    check("window_result", {hi, lo}, {32'd0, 32'd6});
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) bad++;
    end
    check("window_no_relaunch", 64'(bad), 64'd0);
    m_hi = 32'd0; m_lo = 32'd6;

    // reset in the third busy cycle of a DIV aborts it
    run_op(4'd5, 32'h0000_0005, 32'd0, 1'b0, 32'h0000_0005, m_lo);
    @(negedge clk); start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_flags", {62'd0, busy, done}, 64'd0);
    @(negedge clk); reset = 1'b0;
    bad = 0;
    repeat (ND + 2) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
    end
    check("abort_quiet", 64'(bad), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    // randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) ro = 4'($urandom_range(1, 10));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 40)) - 32'd20; rb = 32'($urandom_range(0, 10)) - 32'd5; end
        default: ;
      endcase
      rc = ($urandom_range(0, 7) == 0);
      e = model(ro, ra, rb, rc);
      run_op(ro, ra, rb, rc, e[63:32], e[31:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
